mux_n_to_1_pipe: RTL and testbench

//  Parametrised N:1 word multiplexer with a registered, flow-controlled output stage.
//  A word is selected from NUM_INPUTS buses on each accepted input transfer and held in a 2-entry buffer.
//  The buffer drains over a valid/ready interface.

---
 rtl/mux_n_to_1_pipe_if.sv | 30 +++
 rtl/mux_n_to_1_pipe.sv | 97 +++++++++
 tb/tb_mux_n_to_1_pipe.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_to_1_pipe_if.sv
// Handshake/bus bundle for mux_n_to_1_pipe: valid/ready input side carrying select+buses, valid/ready output side.
// sel_err exists only when MUX_SEL_CHECK_EN is defined.
interface mux_n_to_1_pipe_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // a producer holding valid may not retract its data until it is accepted, and ready never depends on valid.
  logic                             in_valid;
  logic                             in_ready;
  logic [SEL_WIDTH-1:0]             select;
  logic [NUM_INPUTS*WORD_WIDTH-1:0] inp;
  logic                             out_valid;
  logic                             out_ready;
  logic [WORD_WIDTH-1:0]            out;
`ifdef MUX_SEL_CHECK_EN
  logic                             sel_err;

  modport master (output in_valid, select, inp, out_ready,
                  input  in_ready, out_valid, out, sel_err);
  modport slave  (input  in_valid, select, inp, out_ready,
                  output in_ready, out_valid, out, sel_err);
`else
  modport master (output in_valid, select, inp, out_ready,
                  input  in_ready, out_valid, out);
  modport slave  (input  in_valid, select, inp, out_ready,
                  output in_ready, out_valid, out);
`endif
endinterface

// File: rtl/mux_n_to_1_pipe.sv
// N:1 word mux feeding a 2-entry FIFO with valid/ready on both sides; no combinational in->out path.
// Optional sticky out-of-range flag enabled by defining MUX_SEL_CHECK_EN.
module mux_n_to_1_pipe #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
) (
  input logic              clk,
  input logic              rst,
  mux_n_to_1_pipe_if.slave bus
);

  generate
    if (NUM_INPUTS < 2 || (2 ** SEL_WIDTH) < NUM_INPUTS) begin : g_param_check
      $error("mux_n_to_1_pipe: NUM_INPUTS must be >= 2 and fit in SEL_WIDTH bits");
    end
  endgenerate

  logic [1:0]            count;
  logic [WORD_WIDTH-1:0] head_q;
  logic [WORD_WIDTH-1:0] tail_q;
  logic [WORD_WIDTH-1:0] picked;
  logic [WORD_WIDTH-1:0] sel_word;
  logic                  in_range;
  logic                  push;
  logic                  pop;

  always_comb begin
    picked   = '0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (bus.select == SEL_WIDTH'(i)) begin
        picked   = bus.inp[i*WORD_WIDTH +: WORD_WIDTH];
        in_range = 1'b1;
      end
    end
    sel_word = in_range ? picked : '0;
  end

  // in_ready looks only at state (and reset), never at out_ready.
  assign bus.in_ready  = !rst && (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out       = head_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_q <= sel_word;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          // Simultaneous push/pop replaces the head in place.
          if (push && pop) begin
            head_q <= sel_word;
          end else if (push) begin
            tail_q <= sel_word;
            count  <= 2'd2;
          end else if (pop) begin
            count  <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            count  <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic sel_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (push && !in_range) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Bench for mux_n_to_1_pipe: a 4-input and a 3-input instance share stimulus; scoreboard queues
// model the 2-deep FIFO and a negedge monitor compares every visible output.
module tb_mux_n_to_1_pipe;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         in_valid  = 1'b0;
  logic [1:0]   select    = 2'd0;
  logic [127:0] inp       = '0;
  logic         out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp4_q[$];
  logic [W-1:0] exp3_q[$];
  logic         err3_exp = 1'b0;

  mux_n_to_1_pipe_if #(.WORD_WIDTH(W), .NUM_INPUTS(4), .SEL_WIDTH(2)) if4 ();
  mux_n_to_1_pipe_if #(.WORD_WIDTH(W), .NUM_INPUTS(3), .SEL_WIDTH(2)) if3 ();

  assign if4.in_valid  = in_valid;
  assign if4.select    = select;
  assign if4.inp       = inp;
  assign if4.out_ready = out_ready;
  assign if3.in_valid  = in_valid;
  assign if3.select    = select;
  assign if3.inp       = inp[95:0];
  assign if3.out_ready = out_ready;

  mux_n_to_1_pipe #(.WORD_WIDTH(W), .NUM_INPUTS(4), .SEL_WIDTH(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  mux_n_to_1_pipe #(.WORD_WIDTH(W), .NUM_INPUTS(3), .SEL_WIDTH(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  // Clock/reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_word(input int sel, input int n, input logic [127:0] v);
    logic [W-1:0] words[4];
    for (int i = 0; i < 4; i++) words[i] = v[i*W +: W];
    if (sel < n) return words[sel];
    return '0;
  endfunction

  // Monitor + scoreboard: compare what is visible, then apply this edge's pop and push to the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready4", {31'b0, if4.in_ready}, 0);
      check("rst_out_valid4", {31'b0, if4.out_valid}, 0);
      check("rst_out_valid3", {31'b0, if3.out_valid}, 0);
      exp4_q.delete();
      exp3_q.delete();
      err3_exp = 1'b0;
    end else begin
      bit model_valid;
      bit model_push;
      model_valid = (exp4_q.size() != 0);
      model_push  = in_valid && (exp4_q.size() < 2);
      check("out_valid4", {31'b0, if4.out_valid}, {31'b0, model_valid});
      check("out_valid3", {31'b0, if3.out_valid}, {31'b0, model_valid});
      check("in_ready4", {31'b0, if4.in_ready}, {31'b0, exp4_q.size() < 2});
      check("in_ready3", {31'b0, if3.in_ready}, {31'b0, exp3_q.size() < 2});
      if (model_valid) begin
        check("out4", if4.out, exp4_q[0]);
        check("out3", if3.out, exp3_q[0]);
      end
`ifdef MUX_SEL_CHECK_EN
      check("sel_err4", {31'b0, if4.sel_err}, 0);
      check("sel_err3", {31'b0, if3.sel_err}, {31'b0, err3_exp});
      if (model_push && select >= 2'd3) err3_exp = 1'b1;
`endif
      if (model_valid && out_ready) begin
        void'(exp4_q.pop_front());
        void'(exp3_q.pop_front());
      end
      if (model_push) begin
        exp4_q.push_back(ref_word(int'(select), 4, inp));
        exp3_q.push_back(ref_word(int'(select), 3, inp));
      end
    end
  end

  // Driver tasks
  task automatic cycle(input logic iv, input logic [1:0] sel, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    select    = sel;
    out_ready = ordy;
    inp       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_async_out_valid", {31'b0, if4.out_valid}, 0);
    check("rst_async_out", if4.out, 0);
    check("rst_async_in_ready", {31'b0, if4.in_ready}, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp4_q.size() != 0; i++) @(posedge clk);
    check("drain_timeout", exp4_q.size(), 0);
  endtask

  initial begin
    #1;
    check("init_out_valid", {31'b0, if4.out_valid}, 0);
    check("init_out", if4.out, 0);
    check("init_in_ready", {31'b0, if4.in_ready}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single select
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    select    = 2'd2;
    out_ready = 1'b1;
    inp       = {32'h33, 32'h22, 32'h11, 32'h00};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("single_out", if4.out, 32'h22);
    repeat (2) @(posedge clk);

    // Backpressure: two words, buffer full, held for 5 cycles
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    select    = 2'd1;
    @(posedge clk);
    #1;
    select = 2'd3;
    @(posedge clk);
    #1;
    select = 2'd0;
    repeat (5) @(posedge clk);
    #1;
    check("bp_head", if4.out, 32'h11);
    check("bp_in_ready", {31'b0, if4.in_ready}, 0);
    in_valid = 1'b0;
    drain();

    // Streaming, select cycling
    for (int i = 0; i < 16; i++) cycle(1'b1, 2'(i % 4), 1'b1);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
    drain();

    // Mid-operation reset with buffer full
    cycle(1'b1, 2'd3, 1'b0);
    cycle(1'b1, 2'd2, 1'b0);
    cycle(1'b0, 2'd0, 1'b0);
    pulse_reset();
    repeat (3) cycle(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 100; i++)
      cycle($urandom_range(0, 1) != 0, 2'($urandom_range(0, 2)), $urandom_range(0, 3) != 0);
    drain();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
